// File: rtl/cond_exec_unit.sv
// Predicated execution unit: evaluates ARM-style condition codes against a status register and runs IT-style predicated blocks.
// Latency: out_valid/out_exec/sr update one cycle after the issuing edge.
// Backpressure: none; one instruction is accepted every cycle in_valid is high.
module cond_exec_unit #(
    parameter int MAX_BLK = 4,
    parameter int LEN_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [3:0]         in_cond,
    input  logic               in_set_flags,
    input  logic [3:0]         alu_flags,
    input  logic               blk_start,
    input  logic [3:0]         blk_cond,
    input  logic [MAX_BLK-1:0] blk_mask,
    input  logic [LEN_W-1:0]   blk_len,
    output logic               out_valid,
    output logic               out_exec,
    output logic [3:0]         sr,
    output logic               blk_active,
    output logic [LEN_W-1:0]   blk_remaining
);

    typedef enum logic {IDLE, BLOCK} state_t;

    state_t               state_q, state_d;
    logic [3:0]           bcond_q, bcond_d;
    logic [MAX_BLK-1:0]   bmask_q, bmask_d;
    logic [LEN_W-1:0]     blen_q, blen_d;
    logic [LEN_W-1:0]     rem_q, rem_d;
    logic [3:0]           sr_d;
    logic                 valid_d, exec_d;
    logic [LEN_W-1:0]     slot_idx;
    logic [MAX_BLK-1:0]   mask_sh;
    logic [LEN_W-1:0]     len_clamped;
    logic [3:0]           eff_cond;
    logic                 pass;

    // Flags packed {Z,C,N,V}
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic z, cy, n, v;
        z  = f[3];
        cy = f[2];
        n  = f[1];
        v  = f[0];
        case (c)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = ~z;
            4'b0010: cond_pass = cy;
            4'b0011: cond_pass = ~cy;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = ~n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = ~v;
            4'b1000: cond_pass = cy & ~z;
            4'b1001: cond_pass = ~cy | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = ~z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        bcond_d     = bcond_q;
        bmask_d     = bmask_q;
        blen_d      = blen_q;
        rem_d       = rem_q;
        len_clamped = (blk_len > LEN_W'(MAX_BLK)) ? LEN_W'(MAX_BLK) : blk_len;
        slot_idx    = blen_q - rem_q;
        mask_sh     = bmask_q >> slot_idx;
        eff_cond    = in_cond;
        // Inside a block the instruction's own condition is ignored
        if (state_q == BLOCK) begin
            eff_cond = mask_sh[0] ? bcond_q : {bcond_q[3:1], ~bcond_q[0]};
        end
        pass    = cond_pass(eff_cond, sr);
        valid_d = in_valid;
        exec_d  = in_valid & pass;
        sr_d    = (in_valid & in_set_flags & pass) ? alu_flags : sr;

        case (state_q)
            IDLE: begin
                if (blk_start && (blk_len != '0)) begin
                    state_d = BLOCK;
                    bcond_d = blk_cond;
                    bmask_d = blk_mask;
                    blen_d  = len_clamped;
                    rem_d   = len_clamped;
                end
            end
            BLOCK: begin
                if (in_valid) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bcond_q   <= '0;
            bmask_q   <= '0;
            blen_q    <= '0;
            rem_q     <= '0;
            sr        <= '0;
            out_valid <= 1'b0;
            out_exec  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcond_q   <= bcond_d;
            bmask_q   <= bmask_d;
            blen_q    <= blen_d;
            rem_q     <= rem_d;
            sr        <= sr_d;
            out_valid <= valid_d;
            out_exec  <= exec_d;
        end
    end

    assign blk_active    = (state_q == BLOCK);
    assign blk_remaining = rem_q;

endmodule

// File: doc/cond_exec_unit.md
COND_EXEC_UNIT -- requirements
Module: cond_exec_unit

Interface
REQ-001 Parameter MAX_BLK, default 4: maximum number of instructions covered by one predicated block, range 1..8.
REQ-002 Parameter LEN_W, default 3: width of blk_len and blk_remaining; SHALL be >= clog2(MAX_BLK+1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  one instruction issued this cycle.
REQ-006 in_cond  input  4  instruction condition field, standard ARM encoding (0000 EQ ... 1110 AL, 1111 NV).
REQ-007 in_set_flags  input  1  instruction writes flags (S bit).
REQ-008 alu_flags  input  4  instruction result flags, packed {Z,C,N,V}.
REQ-009 blk_start  input  1  open a predicated block.
REQ-010 blk_cond  input  4  block base condition.
REQ-011 blk_mask  input  MAX_BLK  bit i=1: slot i uses blk_cond; bit i=0: slot i uses blk_cond with bit 0 inverted.
REQ-012 blk_len  input  LEN_W  number of instructions in the block.
REQ-013 out_valid  output  1  registered copy of in_valid.
REQ-014 out_exec  output  1  registered: issued instruction passes its effective condition.
REQ-015 sr  output  4  status register, packed {Z,C,N,V}.
REQ-016 blk_active  output  1  a block is open.
REQ-017 blk_remaining  output  LEN_W  instructions left in the open block.

Function
REQ-018 Condition table: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; NV 0.
REQ-019 Effective condition: in_cond when blk_active=0; otherwise slot condition per REQ-011, slot index = blk_len_latched - blk_remaining; in_cond ignored.
REQ-020 Evaluation uses sr as held before the edge; out_valid/out_exec valid one cycle after in_valid (latency 1).
REQ-021 out_exec SHALL be 0 whenever in_valid was 0.
REQ-022 sr <= alu_flags at edge iff in_valid & in_set_flags & condition passes; otherwise sr holds.
REQ-023 Back-to-back instructions: instruction N+1 sees sr updated by instruction N (no bypass needed; 1-cycle register).
REQ-024 States: IDLE (blk_active=0), BLOCK (blk_active=1).
REQ-025 IDLE->BLOCK at edge when blk_start=1 and blk_len!=0; blk_cond, blk_mask, length latched; blk_remaining <= min(blk_len, MAX_BLK).
REQ-026 blk_start with blk_len=0 SHALL be ignored.
REQ-027 blk_start while blk_active=1 SHALL be ignored (no restart, no nesting).
REQ-028 blk_start and in_valid in the same IDLE cycle: that instruction uses its own in_cond; block applies from the next instruction.
REQ-029 In BLOCK each in_valid decrements blk_remaining whether or not the slot executed; cycles without in_valid hold.
REQ-030 BLOCK->IDLE at the edge where blk_remaining goes 1->0; next instruction uses in_cond.
REQ-031 Slot with blk_cond=AL and mask bit 0 yields NV: never executes.
REQ-032 Flag writes inside a block affect conditions of subsequent slots.

Reset
REQ-033 rst=1 at edge: sr=0000, out_valid=0, out_exec=0, blk_active=0, blk_remaining=0, latched block state cleared; dominates all other inputs.
REQ-034 Reset asserted mid-block abandons the block; first instruction after reset is evaluated in IDLE.

Verification
REQ-035 Reset, then in_valid, in_cond=0000 (EQ), sr=0000 -> out_exec=0 next cycle; with in_set_flags, alu_flags=1000 -> sr stays 0000.
REQ-036 Issue AL with S, alu_flags=1000; next cycle EQ -> out_exec=1; next NE -> out_exec=0; sr=1000 throughout.
REQ-037 Sweep all 16 conditions x 16 sr values -> out_exec matches REQ-018 table for all 256 cases.
REQ-038 sr=0010 (N=1,V=0); blk_start, blk_cond=1010 (GE), blk_mask=0101, blk_len=4; issue 4 AL instructions -> out_exec 0,1,0,1; blk_active falls after 4th; 5th instruction executes by in_cond.
REQ-039 blk_len=7 with MAX_BLK=4 -> blk_remaining=4; blk_start again mid-block -> ignored; rst after 2 slots -> blk_active=0, sr=0000.
REQ-040 In block, slot 0 (EQ, mask 1) sets Z via S with sr=1000 (Z=1); slot 1 (mask 0, NE) -> out_exec=0; block slot with blk_cond=AL, mask 0 -> out_exec=0.
